alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 147 ++++++++++++++
 tb/tb_alu_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with a valid/ready request port and a
// registered, back-pressurable result port.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake; ctrl/x/y captured on accept
//   ctrl [3:0], x, y     opcode and WIDTH-bit operands
//   out_valid/out_ready  result handshake; out/flags held until taken
//   out, carry, zero, ovf  registered result and flags
//
// Configuration
//   ALU_SEQ_MUL_EN  defined: opcode 4'b1101 is an iterative shift-add
//                   unsigned multiply (WIDTH+1 cycles accept->result).
//                   undefined: 4'b1101 returns 0 like 4'b1110, and the
//                   multiply datapath and BUSY state are never reached.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2,
                         OP_OR  = 4'h3, OP_NOT = 4'h4, OP_XOR = 4'h5,
                         OP_NOR = 4'h6, OP_SHL = 4'h7, OP_SHR = 4'h8,
                         OP_ASR = 4'h9, OP_ROL = 4'hA, OP_ROR = 4'hB,
                         OP_EQ  = 4'hC;

  state_t           state;
  logic             accept;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign shamt     = x[SHW-1:0];

  // Single-cycle result, computed straight from the request so it can be
  // registered on the accepting edge (one result per cycle when streaming).
  always_comb begin
    sum_ext = {x[WIDTH-1], x} + {y[WIDTH-1], y};
    dif_ext = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (ctrl)
      OP_ADD: begin
        res   = sum_ext[WIDTH-1:0];
        res_c = sum_ext[WIDTH];
        res_v = (x[WIDTH-1] == y[WIDTH-1]) && (sum_ext[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        res   = dif_ext[WIDTH-1:0];
        res_c = dif_ext[WIDTH];
        res_v = (x[WIDTH-1] != y[WIDTH-1]) && (dif_ext[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND: res = x & y;
      OP_OR:  res = x | y;
      OP_NOT: res = ~x;
      OP_XOR: res = x ^ y;
      OP_NOR: res = ~(x | y);
      OP_SHL: res = y << shamt;
      OP_SHR: res = y >> shamt;
      OP_ASR: res = {x[WIDTH-1], x[WIDTH-1:1]};
      OP_ROL: res = {x[WIDTH-2:0], x[WIDTH-1]};
      OP_ROR: res = {x[0], x[WIDTH-1:1]};
      OP_EQ:  res = (x == y) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default: res = '0;  // 1110/1111, and 1101 when multiply is disabled
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'hD;
  localparam logic [SHW:0] CNT_LAST = WIDTH[SHW:0];

  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW:0]       cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
`ifdef ALU_SEQ_MUL_EN
      if (state == BUSY) begin
        // WIDTH shift-add iterations, then one cycle to publish the product.
        if (cnt == CNT_LAST) begin
          out   <= acc[WIDTH-1:0];
          carry <= |acc[2*WIDTH-1:WIDTH];
          zero  <= (acc[WIDTH-1:0] == '0);
          ovf   <= 1'b0;
          state <= DONE;
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
      end else if (accept && ctrl == OP_MUL) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, x};
        mplier <= y;
        cnt    <= '0;
        state  <= BUSY;
      end else
`endif
      if (accept) begin
        out   <= res;
        carry <= res_c;
        zero  <= (res == '0);
        ovf   <= res_v;
        state <= DONE;
      end else if (state == DONE && out_ready) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=8 instance for the main function and
// handshake behaviour, plus a WIDTH=16 instance for modulo shift amounts.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] ctrl;
  logic [7:0] x, y, out;
  logic       carry, zero, ovf;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [3:0]  ctrl16;
  logic [15:0] x16, y16, out16;
  logic        carry16, zero16, ovf16;

  int checks = 0;
  int errors = 0;
  logic [7:0] held;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry(carry), .zero(zero), .ovf(ovf));

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .ctrl(ctrl16), .x(x16), .y(y16), .out_valid(out_valid16),
    .out_ready(out_ready16), .out(out16), .carry(carry16), .zero(zero16),
    .ovf(ovf16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; returns 1 time unit after that edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; ctrl = op; x = a; y = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] o, input logic c,
                         input logic z, input logic v);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".out"},   {24'd0, out}, {24'd0, o});
    chk({tag, ".carry"}, {31'd0, carry}, {31'd0, c});
    chk({tag, ".zero"},  {31'd0, zero},  {31'd0, z});
    chk({tag, ".ovf"},   {31'd0, ovf},   {31'd0, v});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ctrl = 4'h0; x = '0; y = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; ctrl16 = 4'h0; x16 = '0; y16 = '0;
    #2;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out",   {24'd0, out}, 32'd0);
    chk("rst.flags", {29'd0, carry, zero, ovf}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // Single-cycle ops, streamed back to back.
    issue(4'h0, 8'h7F, 8'h01); chk_res("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1);
    issue(4'h1, 8'h00, 8'h01); chk_res("sub_neg", 8'hFF, 1'b1, 1'b0, 1'b0);
    issue(4'h1, 8'h80, 8'h01); chk_res("sub_ovf", 8'h7F, 1'b1, 1'b0, 1'b1);
    issue(4'hC, 8'h5A, 8'h5A); chk_res("eq",      8'h01, 1'b0, 1'b0, 1'b0);
    issue(4'hC, 8'h5A, 8'h5B); chk_res("neq",     8'h00, 1'b0, 1'b1, 1'b0);
    issue(4'h2, 8'hF0, 8'h3C); chk_res("and",     8'h30, 1'b0, 1'b0, 1'b0);
    issue(4'h3, 8'hF0, 8'h0C); chk_res("or",      8'hFC, 1'b0, 1'b0, 1'b0);
    issue(4'h4, 8'h0F, 8'hAA); chk_res("not",     8'hF0, 1'b0, 1'b0, 1'b0);
    issue(4'h5, 8'h5A, 8'h5A); chk_res("xor_z",   8'h00, 1'b0, 1'b1, 1'b0);
    issue(4'h6, 8'h00, 8'h00); chk_res("nor",     8'hFF, 1'b0, 1'b0, 1'b0);
    issue(4'h7, 8'h0B, 8'h01); chk_res("shl_mod", 8'h08, 1'b0, 1'b0, 1'b0);
    issue(4'h8, 8'h0B, 8'h80); chk_res("shr_mod", 8'h10, 1'b0, 1'b0, 1'b0);
    issue(4'h9, 8'h80, 8'h00); chk_res("asr",     8'hC0, 1'b0, 1'b0, 1'b0);
    issue(4'hA, 8'h81, 8'h00); chk_res("rol",     8'h03, 1'b0, 1'b0, 1'b0);
    issue(4'hB, 8'h01, 8'h00); chk_res("ror",     8'h80, 1'b0, 1'b0, 1'b0);
    issue(4'hE, 8'hFF, 8'hFF); chk_res("op_e",    8'h00, 1'b0, 1'b1, 1'b0);
    issue(4'hF, 8'h12, 8'h34); chk_res("op_f",    8'h00, 1'b0, 1'b1, 1'b0);

    // Back-pressure: result must hold while the consumer stalls.
    issue(4'h0, 8'h10, 8'h22);
    out_ready = 1'b0;
    in_valid = 1'b1; ctrl = 4'h5; x = 8'hFF; y = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall.out",      {24'd0, out}, 32'h32);
      chk("stall.valid",    {31'd0, out_valid}, 32'd1);
      chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      x = 8'h11 * i[7:0]; y = 8'hC3;
      held = (8'h11 * i[7:0]) ^ 8'hC3;
      step();
      chk("stream.valid", {31'd0, out_valid}, 32'd1);
      chk("stream.out",   {24'd0, out}, {24'd0, held});
    end
    in_valid = 1'b0;
    step();
    chk("idle.valid",    {31'd0, out_valid}, 32'd0);
    chk("idle.in_ready", {31'd0, in_ready}, 32'd1);

`ifdef ALU_SEQ_MUL_EN
    issue(4'hD, 8'd20, 8'd13);
    for (int i = 0; i < 9; i++) begin
      chk("mul.busy_valid", {31'd0, out_valid}, 32'd0);
      chk("mul.busy_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk_res("mul", 8'h04, 1'b1, 1'b0, 1'b0);
    issue(4'hD, 8'd7, 8'd9);
    for (int i = 0; i < 9; i++) step();
    chk_res("mul_small", 8'd63, 1'b0, 1'b0, 1'b0);

    // Reset during the third cycle of a multiply discards it.
    issue(4'hD, 8'd3, 8'd5);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mulrst.valid", {31'd0, out_valid}, 32'd0);
    chk("mulrst.out",   {24'd0, out}, 32'd0);
`else
    issue(4'hD, 8'd20, 8'd13); chk_res("mul_off", 8'h00, 1'b0, 1'b1, 1'b0);
    issue(4'h0, 8'h01, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("donerst.valid", {31'd0, out_valid}, 32'd0);
    chk("donerst.out",   {24'd0, out}, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst.valid", {31'd0, out_valid}, 32'd0);
    end

    // WIDTH=16: shift amount 0x13 taken modulo 16 -> 3.
    in_valid16 = 1'b1; ctrl16 = 4'h7; x16 = 16'h0013; y16 = 16'h0001;
    step();
    in_valid16 = 1'b0;
    chk("w16.valid", {31'd0, out_valid16}, 32'd1);
    chk("w16.shl",   {16'd0, out16}, 32'h0008);
    chk("w16.flags", {29'd0, carry16, zero16, ovf16}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
